// File: rtl/gcd_iter.sv
// Binary (Stein) GCD coprocessor: operands arrive on a valid/ready port, the result
// and the number of CALC cycles used leave on a second valid/ready port.
module gcd_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(2*WIDTH+2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles
);

    // k never exceeds WIDTH-1, so clog2(WIDTH) bits hold it
    localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [K_W-1:0]   ZERO_K  = {K_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
    localparam logic [K_W-1:0]   ONE_K   = K_W'(1'b1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] x_q,         x_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic [K_W-1:0]   k_q,         k_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [CNT_W-1:0] cycles_q,    cycles_d;
    logic             out_valid_q, out_valid_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] diff_xy;
    logic [WIDTH-1:0] diff_yx;

    // Next-state logic: one Stein reduction step per CALC cycle
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        cycles_d    = cycles_q;
        out_valid_d = out_valid_q;
        cnt_inc     = cnt_q + ONE_C;
        diff_xy     = x_q - y_q;
        diff_yx     = y_q - x_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = ZERO_K;
                    cnt_d   = ZERO_C;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_inc;
                if (x_q == ZERO_W) begin
                    result_d    = y_q << k_q;
                    cycles_d    = cnt_inc;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (y_q == ZERO_W) begin
                    result_d    = x_q << k_q;
                    cycles_d    = cnt_inc;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1'b1;
                    y_d = y_q >> 1'b1;
                    k_d = k_q + ONE_K;
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1'b1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1'b1;
                end else if (x_q >= y_q) begin
                    // both odd: the difference is even, so halving it drops no bits
                    x_d = diff_xy >> 1'b1;
                end else begin
                    y_d = diff_yx >> 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= ZERO_W;
            y_q         <= ZERO_W;
            k_q         <= ZERO_K;
            cnt_q       <= ZERO_C;
            result_q    <= ZERO_W;
            cycles_q    <= ZERO_C;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_iter.sv
// Scoreboard bench for gcd_iter: a driver pushes expected results on accept, a
// negedge monitor pops and compares on every output handshake.
module tb_gcd_iter #(
    parameter int W = 8
);
    localparam int CW    = $clog2(2*W+2);
    localparam int BOUND = 2*W+1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [CW-1:0] cycles;

    gcd_iter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        longint cyc;   // -1: exact count unknown, only the bound applies
        longint acc;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc_cnt = 0;
    int     errors  = 0;
    int     checks  = 0;
    bit     rnd_rdy = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic longint gcd_ref(input longint x, input longint y);
        longint t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input longint va, input longint vb, input longint ec);
        int   n;
        exp_t e;
        a        = W'(va);
        b        = W'(vb);
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", n, 0);
            in_valid = 1'b0;
        end else begin
            e.res = gcd_ref(va, vb);
            e.cyc = ec;
            e.acc = cyc_cnt + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    // Monitor: hold stability, latency, result, cycles and bound
    initial begin
        bit            ov_prev = 1'b0;
        logic [W-1:0]  held_res = '0;
        logic [CW-1:0] held_cyc = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && ov_prev) begin
                    check("hold_result", result, held_res);
                    check("hold_cycles", cycles, held_cyc);
                end
                if (out_valid)
                    check("in_ready_busy", in_ready, 0);
                if (out_valid && !ov_prev) begin
                    if (sb_q.size() == 0)
                        check("unexpected_out", out_valid, 0);
                    else if (sb_q[0].cyc >= 0)
                        check("latency", cyc_cnt - sb_q[0].acc, sb_q[0].cyc);
                    else
                        check("latency", cyc_cnt - sb_q[0].acc, cycles);
                end
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    if (e.cyc >= 0)
                        check("cycles", cycles, e.cyc);
                    check("cycles_bound", (cycles <= BOUND) ? 1 : 0, 1);
                end
                ov_prev  = out_valid;
                held_res = result;
                held_cyc = cycles;
            end
        end
    end

    // Random consumer backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        longint ra, rb;
        int     n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cycles", cycles, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        @(posedge clk); #1;
        out_ready = 1'b1;
        send(12, 18, 5);
        send(255, 1, (W == 8) ? 9 : -1);
        send(0, 0, 1);
        send(0, 7, 1);
        send(200, 0, 1);
        wait_empty();

        // Backpressure: result must hold while the consumer stalls
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(12, 18, 5);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid_hold", out_valid, 1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_empty();

        // Reset during the third CALC cycle aborts the operation
        @(posedge clk); #1;
        send(12, 18, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_out", out_valid, 0);
        check("abort_idle", in_ready, 1);
        @(posedge clk); #1;
        send(35, 21, -1);
        wait_empty();

        // Random back-to-back pairs with random consumer readiness
        @(posedge clk); #1;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 0 : longint'(W'($urandom));
            rb = ($urandom_range(0, 9) == 0) ? 0 : longint'(W'($urandom));
            send(ra, rb, -1);
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
